key_encoder: RTL and testbench
==============================

Name: key_encoder

Overview:
- Upstream stage of the `life` core: converts the six raw touch-key levels from the cap-touch front end into the 3-bit `keys` event code that `life` consumes.
- Per key-vector: 2-flop synchronisation, debounce, priority encoding, then single-cycle event emission with auto-repeat on the arrow keys.
- Runs on the same `clk` that `cap_touch` produces.

Parameters:
- DEBOUNCE, 16: consecutive cycles the synchronised vector must differ from the debounced vector before it is accepted (>=2).
- REPEAT_DELAY, 4096: cycles from the first emit of a held arrow key to its first repeat.
- REPEAT_RATE, 1024: cycles between subsequent repeats.
- CNT_BITS, 16: width of the debounce counter and the repeat counter; must hold max(DEBOUNCE, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- key_up  in  1  raw level, asynchronous to clk.
- key_down  in  1  raw level, asynchronous.
- key_left  in  1  raw level, asynchronous.
- key_right  in  1  raw level, asynchronous.
- key_flip  in  1  raw level, asynchronous.
- key_nxt  in  1  raw level, asynchronous.
- keys  out  3  event code, valid for exactly one cycle; 0 = no event.
- held  out  1  high while any debounced key is down.

Behaviour:
- Codes: NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, FLIP=5, NXT=6; 7 is never driven.
- Priority, highest first: NXT > FLIP > UP > DOWN > LEFT > RIGHT.
- Reset:
  - `keys`=0, `held`=0.
  - Sync flops, debounced vector and counters all 0.
  - FSM goes to IDLE.
  - Reset asserted mid-hold drops all state; no event is emitted until a fresh press is debounced after reset deasserts.
- Sync: the 6-bit raw vector passes through 2 flops, producing `sync`.
- Debounce, evaluated each cycle:
  - `sync`==`deb` -> cnt<=0.
  - Otherwise, cnt==DEBOUNCE-1 -> `deb`<=`sync`, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE cycles never changes `deb`.
- `held` = |`deb`, registered.
- FSM states: IDLE, DELAY, REPEAT, WAIT_REL. `code` = priority encode of `deb`.
  - IDLE: `code`!=0 -> emit `code`, latch it as `cur`, rcnt<=0. Go to DELAY if `cur` is an arrow (1-4), else WAIT_REL.
  - DELAY: `deb`==0 -> IDLE. `code`!=`cur` -> WAIT_REL, no emit. rcnt==REPEAT_DELAY-1 -> emit `cur`, rcnt<=0, go to REPEAT. Otherwise rcnt++.
  - REPEAT: same rules as DELAY, but with REPEAT_RATE and staying in REPEAT.
  - WAIT_REL: `deb`==0 -> IDLE. Nothing is emitted.
- Latency:
  - Raw input first sampled high at edge 1 -> `keys` nonzero after edge DEBOUNCE+3, for one cycle.
  - Repeats follow at first-emit + REPEAT_DELAY, then every REPEAT_RATE.
- Simultaneous presses resolving in one debounce update: the highest-priority key only, emitted once.
- Adding a higher-priority key while one is held: no emit; the FSM goes to WAIT_REL and everything must be released before the next event.
- Release and re-press within DEBOUNCE cycles: invisible; the hold and its repeat timing continue.
- Counters saturate logically: rcnt is always cleared on emit, so it never wraps.

Decomposition:
- `life_pkg` holds:
  - KEY_NONE..KEY_NXT code constants.
  - FSM state encoding (IDLE=0, DELAY=1, REPEAT=2, WAIT_REL=3).
  - A priority-encode function.
- One sub-module, `key_debounce`: 2-flop sync plus counter; parameters DEBOUNCE and CNT_BITS; interface clk, reset, raw[5:0] -> deb[5:0].
- The FSM, repeat counter and output registers stay in `key_encoder`.

Test Plan (DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_RATE=8):
- Reset then idle 50 cycles -> `keys`=0 and `held`=0 every cycle.
- `key_flip` raised at edge 1, held for 100 cycles -> `keys`=5 for exactly one cycle at edge 7, no repeats; `held`=1 until 7 cycles after release.
- `key_up` held for 60 cycles -> `keys`=1 at edges 7, 27, 35, 43, 51, 59; 0 on all other cycles.
- `key_left` pulsed for 3 cycles, then 2-cycle low glitches inside a 40-cycle hold of `key_right` -> no LEFT event; exactly one RIGHT (4) first emit; repeat spacing unchanged by the glitches.
- `key_down` and `key_nxt` raised on the same cycle -> single `keys`=6; no DOWN event until both are released and `key_down` is pressed again.
- `key_up` held, reset asserted for 1 cycle at cycle 30 and `key_up` kept high -> `keys`=0 during reset; next `keys`=1 appears DEBOUNCE+3 cycles after reset deasserts.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared key codes, key-encoder FSM states and key priority encoder.
// Key vector bit order used throughout: {nxt, flip, right, left, down, up}.
package life_pkg;
    localparam logic [2:0] KEY_NONE  = 3'd0;
    localparam logic [2:0] KEY_UP    = 3'd1;
    localparam logic [2:0] KEY_DOWN  = 3'd2;
    localparam logic [2:0] KEY_LEFT  = 3'd3;
    localparam logic [2:0] KEY_RIGHT = 3'd4;
    localparam logic [2:0] KEY_FLIP  = 3'd5;
    localparam logic [2:0] KEY_NXT   = 3'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } key_state_t;

    // NXT > FLIP > UP > DOWN > LEFT > RIGHT
    function automatic logic [2:0] key_priority(input logic [5:0] v);
        return v[5] ? KEY_NXT  :
               v[4] ? KEY_FLIP :
               v[0] ? KEY_UP   :
               v[1] ? KEY_DOWN :
               v[2] ? KEY_LEFT :
               v[3] ? KEY_RIGHT : KEY_NONE;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus shared debounce counter for the 6-bit key vector.
// Ports: clk, reset (sync, active-high), raw[5:0] asynchronous levels in,
//        deb[5:0] debounced vector out.
module key_debounce
    import life_pkg::*;
#(
    parameter int DEBOUNCE = 16,
    parameter int CNT_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] raw,
    output logic [5:0] deb
);
    logic [5:0]          r_s1;
    logic [5:0]          r_sync;
    logic [5:0]          r_deb;
    logic [CNT_BITS-1:0] r_cnt;

    // One counter for the whole vector: any difference must persist
    // DEBOUNCE cycles before the complete synchronised vector is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_sync <= '0;
            r_deb  <= '0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= raw;
            r_sync <= r_s1;
            if (r_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_BITS'(DEBOUNCE - 1)) begin
                r_deb <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
        end
    end

    assign deb = r_deb;
endmodule

// File: rtl/key_encoder.sv
// key_encoder: turns raw touch-key levels into one-cycle event codes with arrow auto-repeat.
// Ports: clk, reset (sync, active-high), key_up/down/left/right/flip/nxt raw levels in,
//        keys[2:0] one-cycle event code (0 = none), held = any debounced key down.
module key_encoder
    import life_pkg::*;
#(
    parameter int DEBOUNCE     = 16,
    parameter int REPEAT_DELAY = 4096,
    parameter int REPEAT_RATE  = 1024,
    parameter int CNT_BITS     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_flip,
    input  logic       key_nxt,
    output logic [2:0] keys,
    output logic       held
);
    logic [5:0]          w_deb;
    logic [2:0]          w_code;
    logic [2:0]          w_emit;
    logic [2:0]          w_cur_nxt;
    logic [CNT_BITS-1:0] w_rcnt_nxt;
    logic [CNT_BITS-1:0] w_limit;
    key_state_t          w_state_nxt;
    key_state_t          r_state;
    logic [2:0]          r_cur;
    logic [CNT_BITS-1:0] r_rcnt;
    logic [2:0]          r_keys;
    logic                r_held;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_BITS (CNT_BITS)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   ({key_nxt, key_flip, key_right, key_left, key_down, key_up}),
        .deb   (w_deb)
    );

    assign w_code  = key_priority(w_deb);
    assign w_limit = (r_state == DELAY) ? CNT_BITS'(REPEAT_DELAY - 1) : CNT_BITS'(REPEAT_RATE - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_rcnt_nxt  = r_rcnt;
        w_emit      = KEY_NONE;
        case (r_state)
            IDLE: begin
                if (w_code != KEY_NONE) begin
                    w_emit      = w_code;
                    w_cur_nxt   = w_code;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = (w_code <= KEY_RIGHT) ? DELAY : WAIT_REL;
                end
            end
            DELAY, REPEAT: begin
                // A change of the winning key (e.g. a higher-priority key
                // added) abandons the hold until everything is released.
                if (w_deb == '0) begin
                    w_state_nxt = IDLE;
                end else if (w_code != r_cur) begin
                    w_state_nxt = WAIT_REL;
                end else if (r_rcnt == w_limit) begin
                    w_emit      = r_cur;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = REPEAT;
                end else begin
                    w_rcnt_nxt = r_rcnt + CNT_BITS'(1);
                end
            end
            default: begin
                if (w_deb == '0) w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cur   <= KEY_NONE;
            r_rcnt  <= '0;
            r_keys  <= KEY_NONE;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_keys  <= w_emit;
            r_held  <= |w_deb;
        end
    end

    assign keys = r_keys;
    assign held = r_held;
endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: randomized and directed self-checking bench for key_encoder against a timeline model.
module tb_key_encoder;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;
    localparam logic [5:0] B_UP = 6'b000001, B_DOWN = 6'b000010, B_LEFT = 6'b000100;
    localparam logic [5:0] B_RIGHT = 6'b001000, B_FLIP = 6'b010000, B_NXT = 6'b100000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] r_raw = '0;
    logic [2:0] keys;
    logic       held;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    key_encoder #(
        .DEBOUNCE     (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .CNT_BITS     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_up    (r_raw[0]),
        .key_down  (r_raw[1]),
        .key_left  (r_raw[2]),
        .key_right (r_raw[3]),
        .key_flip  (r_raw[4]),
        .key_nxt   (r_raw[5]),
        .keys      (keys),
        .held      (held)
    );

    // Reference model: the debounced vector is tracked as a run length of
    // disagreement; events are scheduled on an absolute cycle timeline.
    int         m_t = 0;
    logic [5:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
    int         m_run = 0;
    int         m_cur = 0;
    bit         m_lock = 0;
    int         m_next = 0;
    int         m_p;
    logic [2:0] m_keys = '0;
    logic       m_held = 1'b0;

    function automatic int pri(input logic [5:0] v);
        if (v[5]) return 6;
        if (v[4]) return 5;
        if (v[0]) return 1;
        if (v[1]) return 2;
        if (v[2]) return 3;
        if (v[3]) return 4;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_run = 0;
            m_cur = 0; m_lock = 0; m_keys = '0; m_held = 1'b0;
        end else begin
            m_p = pri(m_deb);
            m_keys = '0;
            m_held = |m_deb;
            if (m_lock) begin
                if (m_deb == '0) m_lock = 0;
            end else if (m_cur == 0) begin
                if (m_p != 0) begin
                    m_keys = 3'(m_p);
                    m_cur = m_p;
                    m_next = m_t + RD;
                    if (m_p > 4) begin
                        m_lock = 1;
                        m_cur = 0;
                    end
                end
            end else if (m_deb == '0) begin
                m_cur = 0;
            end else if (m_p != m_cur) begin
                m_lock = 1;
                m_cur = 0;
            end else if (m_t == m_next) begin
                m_keys = 3'(m_cur);
                m_next = m_t + RR;
            end
            if (m_s2 == m_deb) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DEB) begin
                    m_deb = m_s2;
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = r_raw;
        end
        m_t++;
    end

    task automatic test_reset();
        reset = 1'b1;
        r_raw = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (keys !== 3'd0 || held !== 1'b0) $display("FAIL reset_state keys=%0d held=%0d want 0/0", keys, held);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if (keys !== 3'd0 || held !== 1'b0) $display("FAIL idle cyc=%0d keys=%0d held=%0d want 0/0", i, keys, held);
            else n_pass++;
        end
    endtask

    task automatic test_flip();
        int n_flip = 0;
        int first = -1;
        for (int i = 1; i <= 130; i++) begin
            r_raw = (i <= 100) ? B_FLIP : 6'b0;
            @(negedge clk);
            if (keys == 3'd5) begin
                n_flip++;
                if (first < 0) first = i;
            end
            n_checks++;
            if (keys !== m_keys || held !== m_held) $display("FAIL flip cyc=%0d keys=%0d held=%0d want %0d/%0d", i, keys, held, m_keys, m_held);
            else n_pass++;
        end
        n_checks++;
        if (n_flip != 1 || first != 7) $display("FAIL flip_once count=%0d first=%0d want 1 at 7", n_flip, first);
        else n_pass++;
    endtask

    task automatic test_up();
        int got[$];
        int want[6] = '{7, 27, 35, 43, 51, 59};
        for (int i = 1; i <= 90; i++) begin
            r_raw = (i <= 60) ? B_UP : 6'b0;
            @(negedge clk);
            if (keys != 3'd0) got.push_back(i);
            n_checks++;
            if (keys !== m_keys || held !== m_held) $display("FAIL up cyc=%0d keys=%0d held=%0d want %0d/%0d", i, keys, held, m_keys, m_held);
            else n_pass++;
        end
        n_checks++;
        if (got.size() != 6) $display("FAIL up_count got=%0d want 6", got.size());
        else n_pass++;
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            n_checks++;
            if (got[k] != want[k]) $display("FAIL up_edge idx=%0d got=%0d want %0d", k, got[k], want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int n_left = 0;
        int n_right = 0;
        int g1 = 10 + int'($urandom_range(0, 3));
        int g2 = 20 + int'($urandom_range(0, 3));
        for (int i = 1; i <= 15; i++) begin
            r_raw = (i <= 3) ? B_LEFT : 6'b0;
            @(negedge clk);
            if (keys == 3'd3) n_left++;
            n_checks++;
            if (keys !== m_keys || held !== m_held) $display("FAIL left_glitch cyc=%0d keys=%0d held=%0d want %0d/%0d", i, keys, held, m_keys, m_held);
            else n_pass++;
        end
        for (int i = 1; i <= 70; i++) begin
            r_raw = (i <= 40 && i != g1 && i != g1 + 1 && i != g2 && i != g2 + 1) ? B_RIGHT : 6'b0;
            @(negedge clk);
            if (keys == 3'd4) n_right++;
            n_checks++;
            if (keys !== m_keys || held !== m_held) $display("FAIL right_hold cyc=%0d keys=%0d held=%0d want %0d/%0d", i, keys, held, m_keys, m_held);
            else n_pass++;
        end
        n_checks++;
        if (n_left != 0 || n_right != 4) $display("FAIL glitch_counts left=%0d right=%0d want 0/4", n_left, n_right);
        else n_pass++;
    endtask

    task automatic test_nxt_down();
        int n_nxt = 0;
        int n_down_a = 0;
        int n_down_b = 0;
        for (int i = 1; i <= 110; i++) begin
            r_raw = (i <= 30) ? (B_NXT | B_DOWN) : (i <= 60) ? B_DOWN : (i <= 80) ? 6'b0 : B_DOWN;
            @(negedge clk);
            if (keys == 3'd6) n_nxt++;
            if (keys == 3'd2 && i <= 80) n_down_a++;
            if (keys == 3'd2 && i > 80) n_down_b++;
            n_checks++;
            if (keys !== m_keys || held !== m_held) $display("FAIL nxt_down cyc=%0d keys=%0d held=%0d want %0d/%0d", i, keys, held, m_keys, m_held);
            else n_pass++;
        end
        r_raw = '0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (n_nxt != 1 || n_down_a != 0 || n_down_b != 2) $display("FAIL nxt_down_counts nxt=%0d down_held=%0d down_fresh=%0d want 1/0/2", n_nxt, n_down_a, n_down_b);
        else n_pass++;
    endtask

    task automatic test_reset_hold();
        int delta = -1;
        for (int i = 1; i <= 70; i++) begin
            r_raw = (i <= 60) ? B_UP : 6'b0;
            reset = (i == 30);
            @(negedge clk);
            if (i == 30) begin
                n_checks++;
                if (keys !== 3'd0 || held !== 1'b0) $display("FAIL reset_mid_hold keys=%0d held=%0d want 0/0", keys, held);
                else n_pass++;
            end
            if (i > 30 && delta < 0 && keys == 3'd1) delta = i - 30;
            n_checks++;
            if (keys !== m_keys || held !== m_held) $display("FAIL reset_hold cyc=%0d keys=%0d held=%0d want %0d/%0d", i, keys, held, m_keys, m_held);
            else n_pass++;
        end
        reset = 1'b0;
        n_checks++;
        if (delta != DEB + 3) $display("FAIL reset_relatency got=%0d want %0d", delta, DEB + 3);
        else n_pass++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        int hold = 0;
        logic [5:0] v = '0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0: v = '0;
                    1: v = 6'(1) << $urandom_range(0, 5);
                    2: v = 6'($urandom);
                    default: v = r_raw ^ (6'(1) << $urandom_range(0, 5));
                endcase
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 45));
            end
            hold--;
            r_raw = v;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            n_checks++;
            if (keys !== m_keys || held !== m_held) $display("FAIL random cyc=%0d keys=%0d held=%0d want %0d/%0d", i, keys, held, m_keys, m_held);
            else n_pass++;
        end
        reset = 1'b0;
        r_raw = '0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_flip();
        test_up();
        test_glitch();
        test_nxt_down();
        test_reset_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
